seq_tx: RTL and testbench

Stream transmitter that sources symbol sequences into the highest-number tracking FSM and any other W-bit consumer. Software or a testbench loads up to DEPTH symbols into an internal buffer, then pulses `start`. The block replays the symbols in write order over a valid/ready handshake and pulses `done` when the burst completes. It sits upstream of the max-tracking receiver, as the producing end of its input stream.

---
 rtl/seq_tx.sv | 162 ++++++++++++++++
 tb/tb_seq_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_tx.sv
// seq_tx: buffered symbol-burst transmitter over a valid/ready handshake.
// Symbols are loaded while idle, then replayed in write order after `start`.
// `done` pulses for one cycle at the end of each burst.
// Optional feature macro: SEQ_TX_PEAK_FLAG_EN adds a running-max register
// and the `peak_adv` output.
module seq_tx #(
    parameter int unsigned W     = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     start,
    output logic                     busy,
    output logic                     tx_valid,
    output logic [W-1:0]             tx_data,
    input  logic                     tx_ready,
    output logic                     done
`ifdef SEQ_TX_PEAK_FLAG_EN
    ,
    output logic                     peak_adv
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  sent_q, sent_d;
    logic           tx_valid_q, tx_valid_d;
    logic [W-1:0]   tx_data_q, tx_data_d;
    logic           wr_accept;
    logic           full_w;
    logic [W-1:0]   buf_q [DEPTH];

`ifdef SEQ_TX_PEAK_FLAG_EN
    logic [W-1:0]   run_max_q, run_max_d;
`endif

    assign full_w = (count_q == CW'(DEPTH));

    // Next-state, pointer and output-register logic.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        sent_d     = sent_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        wr_accept  = 1'b0;
`ifdef SEQ_TX_PEAK_FLAG_EN
        run_max_d  = run_max_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (wr_en && !full_w) begin
                    wr_accept = 1'b1;
                    wr_ptr_d  = wr_ptr_q + PW'(1);
                    count_d   = count_q + CW'(1);
                end
                if (start) begin
                    if (count_d != '0) begin
                        state_d    = StSend;
                        tx_valid_d = 1'b1;
                        // An empty buffer means the first symbol is the one being
                        // written this cycle, so bypass the not-yet-written array.
                        tx_data_d  = (count_q == '0) ? wr_data : buf_q[rd_ptr_q];
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StSend: begin
                if (tx_valid_q && tx_ready) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    sent_d   = sent_q + CW'(1);
`ifdef SEQ_TX_PEAK_FLAG_EN
                    if (tx_data_q > run_max_q) begin
                        run_max_d = tx_data_q;
                    end
`endif
                    if (sent_q == count_q - CW'(1)) begin
                        state_d    = StDone;
                        tx_valid_d = 1'b0;
                        tx_data_d  = '0;
                    end else begin
                        tx_data_d = buf_q[rd_ptr_q + PW'(1)];
                    end
                end
            end
            StDone: begin
                state_d  = StIdle;
                count_d  = '0;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                sent_d   = '0;
`ifdef SEQ_TX_PEAK_FLAG_EN
                run_max_d = '0;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sent_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sent_q     <= sent_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Symbol storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            buf_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef SEQ_TX_PEAK_FLAG_EN
    // Running maximum of symbols handed off in the current burst.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_max_q <= '0;
        end else begin
            run_max_q <= run_max_d;
        end
    end

    assign peak_adv = tx_valid_q && (tx_data_q > run_max_q);
`endif

    assign full     = full_w;
    assign count    = count_q;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_seq_tx.sv
// Directed bench for seq_tx (W=2, DEPTH=8): per-cycle vector table plus a
// hand-written asynchronous-reset-mid-burst sequence.
module tb_seq_tx;

    logic       clk;
    logic       rstn;
    logic       wr_en;
    logic [1:0] wr_data;
    logic       full;
    logic [3:0] count;
    logic       start;
    logic       busy;
    logic       tx_valid;
    logic [1:0] tx_data;
    logic       tx_ready;
    logic       done;
`ifdef SEQ_TX_PEAK_FLAG_EN
    logic       peak_adv;
`endif

    int checks = 0;
    int errors = 0;

    seq_tx #(.W(2), .DEPTH(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .count    (count),
        .start    (start),
        .busy     (busy),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .done     (done)
`ifdef SEQ_TX_PEAK_FLAG_EN
        ,
        .peak_adv (peak_adv)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per clock cycle: inputs driven for the cycle, outputs
    // expected during it (before the edge that samples those inputs).
    typedef struct {
        logic       wr;
        logic [1:0] wd;
        logic       st;
        logic       rdy;
        logic       ev;
        logic [1:0] ed;
        logic       edn;
        logic       eb;
        logic       ef;
        logic [3:0] ec;
        logic       ep;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic wr, input logic [1:0] wd, input logic st,
                       input logic rdy, input logic ev, input logic [1:0] ed,
                       input logic edn, input logic eb, input logic ef,
                       input logic [3:0] ec, input logic ep);
        vec_t v;
        v.wr = wr; v.wd = wd; v.st = st; v.rdy = rdy; v.ev = ev; v.ed = ed;
        v.edn = edn; v.eb = eb; v.ef = ef; v.ec = ec; v.ep = ep;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {tx_valid, tx_data, done, busy, full, count};
    endfunction

    logic [1:0] got[$];
    int         done_at;
    int         seen_done;
    logic [1:0] exp3[3];

    initial begin
        rstn = 1'b0; wr_en = 1'b0; wr_data = '0; start = 1'b0; tx_ready = 1'b0;
        #2;
        check("reset_outputs", 32'(outs()), 32'h0);

        // Burst 1,0,3,2 with tx_ready held high.
        add(1,1,0,0, 0,0,0,0,0,0,0);
        add(1,0,0,0, 0,0,0,0,0,1,0);
        add(1,3,0,0, 0,0,0,0,0,2,0);
        add(1,2,0,0, 0,0,0,0,0,3,0);
        add(0,0,1,1, 0,0,0,0,0,4,0);
        add(0,0,0,1, 1,1,0,1,0,4,1);
        add(0,0,0,1, 1,0,0,1,0,4,0);
        add(0,0,0,1, 1,3,0,1,0,4,1);
        add(0,0,0,1, 1,2,0,1,0,4,0);
        add(0,0,0,0, 0,0,1,1,0,4,0);
        add(0,0,0,0, 0,0,0,0,0,0,0);
        // Same load, tx_ready toggling 1,0,0,1,...; stray wr_en/start while sending.
        add(1,1,0,0, 0,0,0,0,0,0,0);
        add(1,0,0,0, 0,0,0,0,0,1,0);
        add(1,3,0,0, 0,0,0,0,0,2,0);
        add(1,2,0,0, 0,0,0,0,0,3,0);
        add(0,0,1,0, 0,0,0,0,0,4,0);
        add(0,0,0,1, 1,1,0,1,0,4,1);
        add(1,3,0,0, 1,0,0,1,0,4,0);
        add(0,0,1,0, 1,0,0,1,0,4,0);
        add(0,0,0,1, 1,0,0,1,0,4,0);
        add(0,0,0,1, 1,3,0,1,0,4,1);
        add(0,0,0,0, 1,2,0,1,0,4,0);
        add(0,0,0,0, 1,2,0,1,0,4,0);
        add(0,0,0,1, 1,2,0,1,0,4,0);
        add(0,0,0,0, 0,0,1,1,0,4,0);
        add(0,0,0,0, 0,0,0,0,0,0,0);
        // Nine writes into eight slots: last write (3) must not clobber slot 0.
        for (int i = 0; i < 9; i++) begin
            add(1, (i == 8) ? 2'd3 : 2'(i % 4), 0, 0, 0, 0, 0, 0,
                (i == 8) ? 1'b1 : 1'b0, 4'(i), 0);
        end
        add(0,0,1,1, 0,0,0,0,1,8,0);
        for (int j = 0; j < 8; j++) begin
            add(0, 0, 0, 1, 1, 2'(j % 4), 0, 1, 1, 8,
                (j >= 1 && j <= 3) ? 1'b1 : 1'b0);
        end
        add(0,0,0,0, 0,0,1,1,1,8,0);
        add(0,0,0,0, 0,0,0,0,0,0,0);
        // Empty start, then start together with a single write of 2.
        add(0,0,1,1, 0,0,0,0,0,0,0);
        add(0,0,0,1, 0,0,1,1,0,0,0);
        add(1,2,1,1, 0,0,0,0,0,0,0);
        add(0,0,0,1, 1,2,0,1,0,1,1);
        add(0,0,0,1, 0,0,1,1,0,1,0);
        add(0,0,0,0, 0,0,0,0,0,0,0);

        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < vecs.size(); k++) begin
            wr_en = vecs[k].wr; wr_data = vecs[k].wd;
            start = vecs[k].st; tx_ready = vecs[k].rdy;
            @(negedge clk);
            check($sformatf("vec%0d", k), 32'(outs()),
                  32'({vecs[k].ev, vecs[k].ed, vecs[k].edn, vecs[k].eb,
                       vecs[k].ef, vecs[k].ec}));
`ifdef SEQ_TX_PEAK_FLAG_EN
            check($sformatf("peak%0d", k), 32'(peak_adv), 32'(vecs[k].ep));
`endif
            @(posedge clk); #1;
        end
        wr_en = 1'b0; start = 1'b0; tx_ready = 1'b0;

        // Reset after the 2nd handshake of a 4-symbol burst.
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 2'(i);
            @(posedge clk); #1;
        end
        wr_en = 1'b0; start = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_third_symbol", 32'({tx_valid, tx_data}), 32'({1'b1, 2'd2}));
        #2 rstn = 1'b0;
        #1;
        check("async_reset_outputs", 32'(outs()), 32'h0);
        seen_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check("no_done_in_reset", 32'(seen_done), 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", 32'(outs()), 32'h0);

        // Fresh load of three symbols replays in order.
        exp3[0] = 2'd2; exp3[1] = 2'd3; exp3[2] = 2'd1;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = exp3[i];
            @(posedge clk); #1;
        end
        wr_en = 1'b0; start = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_at = -1;
        got.delete();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (tx_valid) got.push_back(tx_data);
            if (done && done_at < 0) done_at = c;
        end
        check("replay_len", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("replay_sym%0d", i),
                  (i < got.size()) ? 32'(got[i]) : 32'hffff_ffff, 32'(exp3[i]));
        end
        check("replay_done_cycle", 32'(done_at), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
